// File: rtl/id_hazard_scoreboard_if.sv
// Purpose: decode-side bundle between the ID stage and the hazard scoreboard.
// Latency: wires only; no storage.
// Backpressure: freeze/flush travel toward the scoreboard, hazard/id_issue come back.
interface id_hazard_scoreboard_if #(
  parameter int REG_FILE_DEPTH  = 4,
  parameter int STALL_CNT_WIDTH = 16
);
  logic                          id_valid;
  logic [REG_FILE_DEPTH-1:0]     id_src1;
  logic                          id_src1_used;
  logic [REG_FILE_DEPTH-1:0]     id_src2;
  logic                          id_src2_used;
  logic [REG_FILE_DEPTH-1:0]     id_dst;
  logic                          id_wb_en;
  logic                          id_mem_read;
  logic                          id_update;
  logic                          id_cond_used;
  logic                          freeze;
  logic                          flush;
  logic                          hazard;
  logic                          id_issue;
  logic [2**REG_FILE_DEPTH-1:0]  pending_mask;
  logic [STALL_CNT_WIDTH-1:0]    stall_count;

  // decode stage / pipeline control side
  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used, id_dst,
           id_wb_en, id_mem_read, id_update, id_cond_used, freeze, flush,
    input  hazard, id_issue, pending_mask, stall_count
  );

  // scoreboard side
  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used, id_dst,
           id_wb_en, id_mem_read, id_update, id_cond_used, freeze, flush,
    output hazard, id_issue, pending_mask, stall_count
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Purpose: decide each cycle whether the ID instruction may issue, tracking in-flight Rd writes and flag updates.
// Latency: hazard/id_issue/pending_mask are combinational; the shadow slots advance one stage per unfrozen edge.
// Backpressure: hazard holds ID and injects a bubble into EXE; freeze holds both slots and the stall counter.
module id_hazard_scoreboard #(
  parameter int REG_FILE_DEPTH  = 4,
  parameter int FORWARD_EN      = 0,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  id_hazard_scoreboard_if.slave i_sb
);

  localparam int                         LP_NREG    = 2**REG_FILE_DEPTH;
  localparam logic                       LP_FWD     = (FORWARD_EN != 0);
  localparam logic [STALL_CNT_WIDTH-1:0] LP_CNT_ONE = STALL_CNT_WIDTH'(1);

  // producer currently in EXE: ld marks a load whose data only exists after MEM
  typedef struct packed {
    logic                      wb;
    logic [REG_FILE_DEPTH-1:0] dst;
    logic                      ld;
    logic                      upd;
  } exe_slot_t;

  // producer currently in MEM; WB writes through so nothing is tracked beyond here
  typedef struct packed {
    logic                      wb;
    logic [REG_FILE_DEPTH-1:0] dst;
  } mem_slot_t;

  exe_slot_t                  r_exe;
  mem_slot_t                  r_mem;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  exe_slot_t                  w_exe_nxt;
  logic                       w_raw1;
  logic                       w_raw2;
  logic                       w_flag;
  logic                       w_hazard;
  logic                       w_issue;
  logic                       w_cnt_sat;
  logic [LP_NREG-1:0]         w_pmask;

  // A source only matches a producer that really writes Rd. With forwarding only a
  // load in EXE is unresolvable; without it any EXE or MEM producer blocks the read.
  function automatic logic f_raw(input logic [REG_FILE_DEPTH-1:0] src,
                                 input logic                      used,
                                 input exe_slot_t                 e,
                                 input mem_slot_t                 m);
    logic hit_e;
    logic hit_m;
    hit_e = e.wb & (e.dst == src) & (~LP_FWD | e.ld);
    hit_m = ~LP_FWD & m.wb & (m.dst == src);
    return used & (hit_e | hit_m);
  endfunction

  // hazard and issue decision; a flushed ID slot never stalls and never issues
  always_comb begin
    w_raw1   = f_raw(i_sb.id_src1, i_sb.id_src1_used, r_exe, r_mem);
    w_raw2   = f_raw(i_sb.id_src2, i_sb.id_src2_used, r_exe, r_mem);
    w_flag   = i_sb.id_cond_used & r_exe.upd;
    w_hazard = i_sb.id_valid & ~i_sb.flush & (w_raw1 | w_raw2 | w_flag);
    w_issue  = i_sb.id_valid & ~w_hazard & ~i_sb.freeze & ~i_sb.flush;
  end

  // what enters EXE at the next unfrozen edge: the issuing instruction or a bubble
  always_comb begin
    w_exe_nxt = '0;
    if (w_issue) begin
      w_exe_nxt.wb  = i_sb.id_wb_en;
      w_exe_nxt.dst = i_sb.id_dst;
      w_exe_nxt.ld  = i_sb.id_mem_read & i_sb.id_wb_en;
      w_exe_nxt.upd = i_sb.id_update;
    end
  end

  // one-hot OR of both in-flight destinations; same target in both slots gives one bit
  always_comb begin
    w_pmask = '0;
    if (r_exe.wb) w_pmask[r_exe.dst] = 1'b1;
    if (r_mem.wb) w_pmask[r_mem.dst] = 1'b1;
  end

  // shadow pipeline advance; freeze wins over flush so frozen slots keep their contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
    end else if (!i_sb.freeze) begin
      r_mem.wb  <= r_exe.wb;
      r_mem.dst <= r_exe.dst;
      r_exe     <= w_exe_nxt;
    end
  end

  assign w_cnt_sat = &r_stall_cnt;

  // saturating count of cycles lost to hazards; frozen cycles are not charged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!i_sb.freeze && w_hazard && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
    end
  end

  assign i_sb.hazard       = w_hazard;
  assign i_sb.id_issue     = w_issue;
  assign i_sb.pending_mask = w_pmask;
  assign i_sb.stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Purpose: directed scoreboard bench for the ID hazard scheduler (no forwarding, forwarding, narrow counter).
// Latency: stimulus applied 1ns after posedge, outputs sampled on the following negedge.
// Backpressure: freeze/flush exercised directly from the vector list.
module tb_id_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v, s1u, s2u, wb, mr, upd, cnd, frz, fl;
  logic [3:0] s1, s2, dst;

  id_hazard_scoreboard_if #(.REG_FILE_DEPTH(4), .STALL_CNT_WIDTH(16)) if0 ();
  id_hazard_scoreboard_if #(.REG_FILE_DEPTH(4), .STALL_CNT_WIDTH(16)) if1 ();
  id_hazard_scoreboard_if #(.REG_FILE_DEPTH(4), .STALL_CNT_WIDTH(2))  if2 ();

  assign if0.id_valid = v;   assign if0.id_src1 = s1; assign if0.id_src1_used = s1u; assign if0.id_src2 = s2;
  assign if0.id_src2_used = s2u; assign if0.id_dst = dst; assign if0.id_wb_en = wb; assign if0.id_mem_read = mr;
  assign if0.id_update = upd; assign if0.id_cond_used = cnd; assign if0.freeze = frz; assign if0.flush = fl;
  assign if1.id_valid = v;   assign if1.id_src1 = s1; assign if1.id_src1_used = s1u; assign if1.id_src2 = s2;
  assign if1.id_src2_used = s2u; assign if1.id_dst = dst; assign if1.id_wb_en = wb; assign if1.id_mem_read = mr;
  assign if1.id_update = upd; assign if1.id_cond_used = cnd; assign if1.freeze = frz; assign if1.flush = fl;
  assign if2.id_valid = v;   assign if2.id_src1 = s1; assign if2.id_src1_used = s1u; assign if2.id_src2 = s2;
  assign if2.id_src2_used = s2u; assign if2.id_dst = dst; assign if2.id_wb_en = wb; assign if2.id_mem_read = mr;
  assign if2.id_update = upd; assign if2.id_cond_used = cnd; assign if2.freeze = frz; assign if2.flush = fl;

  id_hazard_scoreboard #(.REG_FILE_DEPTH(4), .FORWARD_EN(0), .STALL_CNT_WIDTH(16)) u_dut0 (.clk(clk), .rst(rst), .i_sb(if0.slave));
  id_hazard_scoreboard #(.REG_FILE_DEPTH(4), .FORWARD_EN(1), .STALL_CNT_WIDTH(16)) u_dut1 (.clk(clk), .rst(rst), .i_sb(if1.slave));
  id_hazard_scoreboard #(.REG_FILE_DEPTH(4), .FORWARD_EN(0), .STALL_CNT_WIDTH(2))  u_dut2 (.clk(clk), .rst(rst), .i_sb(if2.slave));

  typedef struct {
    int          sel;  // 0: no-forwarding units (if0, if2), 1: forwarding unit (if1)
    logic        hz;
    logic        is;
    logic [15:0] pm;
    logic [15:0] sc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // monitor: pops one expectation per sampled cycle and compares the selected unit
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.sel == 0) begin
        chk({e.nm, "/hazard"},   32'(if0.hazard),       32'(e.hz));
        chk({e.nm, "/issue"},    32'(if0.id_issue),     32'(e.is));
        chk({e.nm, "/pmask"},    32'(if0.pending_mask), 32'(e.pm));
        chk({e.nm, "/stalls"},   32'(if0.stall_count),  32'(e.sc));
        chk({e.nm, "/sat_cnt"},  32'(if2.stall_count),  (e.sc > 16'd3) ? 32'd3 : 32'(e.sc));
      end else begin
        chk({e.nm, "/hazard"},   32'(if1.hazard),       32'(e.hz));
        chk({e.nm, "/issue"},    32'(if1.id_issue),     32'(e.is));
        chk({e.nm, "/pmask"},    32'(if1.pending_mask), 32'(e.pm));
        chk({e.nm, "/stalls"},   32'(if1.stall_count),  32'(e.sc));
      end
    end
  end

  // instruction fields: valid, src1, src1_used, src2, src2_used, dst, wb_en, mem_read, update, cond_used
  task automatic ins(input int a_v, input int a_s1, input int a_s1u, input int a_s2, input int a_s2u,
                     input int a_d, input int a_wb, input int a_mr, input int a_upd, input int a_cnd);
    v = 1'(a_v); s1 = 4'(a_s1); s1u = 1'(a_s1u); s2 = 4'(a_s2); s2u = 1'(a_s2u);
    dst = 4'(a_d); wb = 1'(a_wb); mr = 1'(a_mr); upd = 1'(a_upd); cnd = 1'(a_cnd);
  endtask

  // queue the expected response for the current cycle, then advance to just past the next edge
  task automatic step(input int sel, input int hz, input int is, input int pm, input int sc, input string nm);
    exp_t t;
    t.sel = sel; t.hz = 1'(hz); t.is = 1'(is); t.pm = 16'(pm); t.sc = 16'(sc); t.nm = nm;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int sel);
    rst = 1'b1; frz = 1'b0; fl = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(sel, 0, 0, 0, 0, "reset");
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    frz = 1'b0; fl = 1'b0;
    ins(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    // reset state: nothing pending, a valid ID issues
    step(0, 0, 1, 0, 0, "rst0");
    step(1, 0, 1, 0, 0, "rst1");
    rst = 1'b0;

    // ---- no forwarding: back-to-back and one-apart dependencies
    ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 0, "A0_add_r1");
    ins(1, 1, 1, 0, 0, 2, 1, 0, 0, 0); step(0, 1, 0, 'h0002, 0, "A1_raw_exe");
                                       step(0, 1, 0, 'h0002, 1, "A2_raw_mem");
                                       step(0, 0, 1, 'h0000, 2, "A3_issue");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0004, 2, "A4_bub");
                                       step(0, 0, 0, 'h0004, 2, "A5_bub");
    ins(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 2, "A6_add_r3");
    ins(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); step(0, 0, 1, 'h0008, 2, "A7_mov_r4");
    ins(1, 0, 0, 3, 1, 5, 1, 0, 0, 0); step(0, 1, 0, 'h0018, 2, "A8_raw_gap");
                                       step(0, 0, 1, 'h0010, 3, "A9_issue");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0020, 3, "A10_bub");
    ins(1, 0, 0, 0, 0, 6, 0, 0, 0, 0); step(0, 0, 1, 'h0020, 3, "A11_str");
    ins(1, 6, 1, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 1, 'h0000, 3, "A12_no_wb_dep");
    ins(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 3, "A13_r7");
                                       step(0, 0, 1, 'h0080, 3, "A14_r7");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0080, 3, "A15_same_dst");
                                       step(0, 0, 0, 'h0080, 3, "A16_bub");
    ins(1, 0, 0, 0, 0, 8, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 3, "A17_r8");
    ins(1, 8, 1, 0, 0, 9, 1, 0, 0, 0); step(0, 1, 0, 'h0100, 3, "A18_raw");
                                       step(0, 1, 0, 'h0100, 4, "A19_raw_sat");
                                       step(0, 0, 1, 'h0000, 5, "A20_issue");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0200, 5, "A21_bub");
                                       step(0, 0, 0, 'h0200, 5, "A22_bub");

    // ---- freeze in the middle of a pending stall
    do_reset(0);
    ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 0, "F0_add_r1");
    ins(1, 1, 1, 0, 0, 4, 1, 0, 0, 0); step(0, 1, 0, 'h0002, 0, "F1_raw");
    frz = 1'b1;                        step(0, 1, 0, 'h0002, 1, "F2_frz");
                                       step(0, 1, 0, 'h0002, 1, "F3_frz");
                                       step(0, 1, 0, 'h0002, 1, "F4_frz");
    frz = 1'b0;                        step(0, 1, 0, 'h0002, 1, "F5_resume");
                                       step(0, 0, 1, 'h0000, 2, "F6_issue");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0010, 2, "F7_bub");
                                       step(0, 0, 0, 'h0010, 2, "F8_bub");

    // ---- flush alone, then flush together with freeze
    do_reset(0);
    ins(1, 0, 0, 0, 0, 1, 1, 0, 1, 0); step(0, 0, 1, 'h0000, 0, "L0_adds_r1");
    ins(1, 1, 1, 0, 0, 2, 1, 0, 1, 1); fl = 1'b1;
                                       step(0, 0, 0, 'h0002, 0, "L1_flush");
    fl = 1'b0;
    ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); step(0, 0, 1, 'h0002, 0, "L2_after_flush");
    ins(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 0, "L3_add_r5");
    ins(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); fl = 1'b1; frz = 1'b1;
                                       step(0, 0, 0, 'h0020, 0, "L4_flush_frz");
    fl = 1'b0; frz = 1'b0;             step(0, 1, 0, 'h0020, 0, "L5_slots_held");
                                       step(0, 1, 0, 'h0020, 1, "L6_raw_mem");
                                       step(0, 0, 1, 'h0000, 2, "L7_issue");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0040, 2, "L8_bub");
                                       step(0, 0, 0, 'h0040, 2, "L9_bub");

    // ---- build pending_mask=0x0006 with 5 stalls, then reset between edges
    do_reset(0);
    ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 0, "R0");
    ins(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step(0, 1, 0, 'h0002, 0, "R1");
                                       step(0, 1, 0, 'h0002, 1, "R2");
                                       step(0, 0, 1, 'h0000, 2, "R3");
    ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 2, "R4");
    ins(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step(0, 1, 0, 'h0002, 2, "R5");
                                       step(0, 1, 0, 'h0002, 3, "R6");
                                       step(0, 0, 1, 'h0000, 4, "R7");
    ins(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 4, "R8");
    ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 1, 'h0008, 4, "R9");
    ins(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step(0, 1, 0, 'h0008, 4, "R10");
                                       step(0, 0, 1, 'h0000, 5, "R11");
    ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step(0, 0, 1, 'h0000, 5, "R12");
    ins(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step(0, 0, 1, 'h0002, 5, "R13");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); frz = 1'b1;
                                       step(0, 0, 0, 'h0006, 5, "R14_armed");
    rst = 1'b1; frz = 1'b0;
    ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 1, 'h0000, 0, "R15_async_rst");
    rst = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 'h0000, 0, "R16_after_rst");

    // ---- forwarding unit: load-use, ALU-use, no-wb load, flag dependency
    do_reset(1);
    ins(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); step(1, 0, 1, 'h0000, 0, "B0_ldr_r2");
    ins(1, 0, 0, 2, 1, 3, 1, 0, 0, 0); step(1, 1, 0, 'h0004, 0, "B1_load_use");
                                       step(1, 0, 1, 'h0004, 1, "B2_issue");
    ins(1, 3, 1, 0, 0, 4, 1, 0, 0, 0); step(1, 0, 1, 'h0008, 1, "B3_alu_use");
    ins(1, 0, 0, 0, 0, 5, 0, 1, 0, 0); step(1, 0, 1, 'h0018, 1, "B4_ld_nowb");
    ins(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step(1, 0, 1, 'h0010, 1, "B5_no_stall");
    ins(1, 0, 0, 0, 0, 7, 0, 0, 1, 0); step(1, 0, 1, 'h0000, 1, "B6_cmp");
    ins(1, 0, 0, 0, 0, 8, 1, 0, 0, 1); step(1, 1, 0, 'h0000, 1, "B7_flag");
                                       step(1, 0, 1, 'h0000, 2, "B8_issue");
    ins(1, 0, 0, 0, 0, 9, 0, 0, 1, 0); step(1, 0, 1, 'h0100, 2, "B9_cmp");
    ins(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); step(1, 0, 1, 'h0100, 2, "B10_no_cond");
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 'h0000, 2, "B11_bub");

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
